fifo_wr_arbiter: RTL and testbench

- Round-robin write-port arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
- Each requester wins a burst, streams beats until it marks one as last, then the grant rotates.
- Drives the FIFO write_en/data_in directly and honours the FIFO full flag as backpressure.
- Sits between producer blocks and the FIFO write side, all in one clock domain.

---
 rtl/fifo_wr_arbiter.sv | 140 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port across burst requesters.
// Define ARB_BURST_LIMIT_EN to cap each burst at MAX_BURST beats.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int data_width = 8,
  parameter int MAX_BURST  = 8,
  parameter int ptr_width  = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            last,
  input  logic [NUM_REQ*data_width-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            grant,
  output logic [NUM_REQ-1:0]            ack,
  output logic                          write_en,
  output logic [data_width-1:0]         data_in,
  output logic                          busy,
  output logic                          burst_abort
);

  typedef enum logic {
    IDLE,
    BURST
  } state_e;

  state_e               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [ptr_width-1:0] rr_ptr_q, rr_ptr_d;
  logic [ptr_width-1:0] owner_q, owner_d;
  logic [ptr_width-1:0] owner_nxt;
  logic [ptr_width-1:0] sel;
  logic                 busy_q, busy_d;
  logic                 abort_q, abort_d;
  logic                 in_burst;
  logic                 accept;
  logic                 drop;
  logic                 end_burst;
  logic                 limit_hit;
  int                   idx;

  assign in_burst  = (state_q == BURST);
  assign accept    = in_burst & req[owner_q] & ~full;
  assign drop      = in_burst & ~req[owner_q];
  assign end_burst = accept & (last[owner_q] | limit_hit);
  assign owner_nxt = (owner_q == ptr_width'(NUM_REQ - 1)) ?
                     '0 : owner_q + 1'b1;

  // First requester at or above rr_ptr, wrapping.
  always_comb begin
    sel = '0;
    idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (req[idx]) sel = ptr_width'(idx);
    end
  end

`ifdef ARB_BURST_LIMIT_EN
  localparam int CW = $clog2(MAX_BURST + 1);
  logic [CW-1:0] cnt_q, cnt_d;

  assign limit_hit = (cnt_q == CW'(MAX_BURST - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!in_burst)   cnt_d = '0;
    else if (accept) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign limit_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      owner_q  <= '0;
      busy_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      owner_q  <= owner_d;
      busy_q   <= busy_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    owner_d  = owner_q;
    busy_d   = busy_q;
    abort_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d      = BURST;
          grant_d      = '0;
          grant_d[sel] = 1'b1;
          owner_d      = sel;
          busy_d       = 1'b1;
        end
      end
      BURST: begin
        if (drop || end_burst) begin
          state_d  = IDLE;
          grant_d  = '0;
          busy_d   = 1'b0;
          rr_ptr_d = owner_nxt;
          abort_d  = drop;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset gates the write side in the same cycle it is asserted.
  always_comb begin
    write_en    = accept & ~reset;
    ack         = (accept & ~reset) ? grant_q : '0;
    data_in     = '0;
    if (in_burst && !reset)
      data_in = req_data[owner_q*data_width +: data_width];
    grant       = grant_q;
    busy        = busy_q;
    burst_abort = abort_q;
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter.
// Expected beats are queued at stimulus time and popped on write_en.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] req;
  logic [N-1:0] last;
  logic [N*W-1:0] req_data;
  logic         full;
  logic [N-1:0] grant;
  logic [N-1:0] ack;
  logic         write_en;
  logic [W-1:0] data_in;
  logic         busy;
  logic         burst_abort;

  typedef struct packed {
    logic [7:0] id;
    logic [7:0] data;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int errors = 0;
  int k;

  fifo_wr_arbiter #(
    .NUM_REQ(N), .data_width(W), .MAX_BURST(8)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .last(last),
    .req_data(req_data), .full(full), .grant(grant),
    .ack(ack), .write_en(write_en), .data_in(data_in),
    .busy(busy), .burst_abort(burst_abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int id, input logic [7:0] d);
    sb.push_back({8'(id), d});
  endtask

  task automatic set_beat(input int i, input logic [7:0] d);
    req_data[i*W +: W] = d;
  endtask

  task automatic idle_in();
    req = '0;
    last = '0;
    full = 1'b0;
    req_data = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Mid-cycle sample: every write must match the queue head.
  task automatic mon();
    beat_t e;
    #3;
    if (write_en === 1'b1) begin
      if (sb.size() == 0) begin
        chk("sb_extra_write", 32'(data_in), 32'hFFFF);
      end else begin
        e = sb.pop_front();
        chk("wr_ack", 32'(ack), 32'(1) << e.id);
        chk("wr_data", 32'(data_in), 32'(e.data));
      end
    end else begin
      chk("ack_idle", 32'(ack), 0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = '1;
    last = '1;
    full = 1'b0;
    req_data = '1;
    repeat (2) @(posedge clk);
    #4;
    chk("rst_grant", 32'(grant), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_abort", 32'(burst_abort), 0);
    chk("rst_we", 32'(write_en), 0);
    chk("rst_ack", 32'(ack), 0);
    chk("rst_data", 32'(data_in), 0);

    // single requester, three beats
    do_reset();
    req = 4'b0010;
    set_beat(1, 8'hA1);
    push(1, 8'hA1);
    push(1, 8'hA2);
    push(1, 8'hA3);
    mon();
    chk("t1_c0_grant", 32'(grant), 0);
    next_cycle();
    mon();
    chk("t1_c1_grant", 32'(grant), 32'b0010);
    chk("t1_c1_busy", 32'(busy), 1);
    next_cycle();
    set_beat(1, 8'hA2);
    mon();
    next_cycle();
    set_beat(1, 8'hA3);
    last = 4'b0010;
    mon();
    next_cycle();
    req = 4'b0101;
    last = 4'b0101;
    set_beat(0, 8'h50);
    set_beat(2, 8'h5A);
    push(2, 8'h5A);
    mon();
    chk("t1_c4_grant", 32'(grant), 0);
    chk("t1_c4_busy", 32'(busy), 0);
    next_cycle();
    mon();
    chk("t1_rr_grant", 32'(grant), 32'b0100);
    next_cycle();
    idle_in();
    mon();
    chk("t1_drain", sb.size(), 0);

    // fairness with single-beat bursts
    do_reset();
    req = 4'b1111;
    last = 4'b1111;
    for (int i = 0; i < N; i++) set_beat(i, 8'(8'h10 + i));
    for (int i = 0; i < 5; i++) push(i % N, 8'(8'h10 + (i % N)));
    for (int c = 0; c < 10; c++) begin
      if (c > 0) next_cycle();
      mon();
      chk("t2_we_gap", 32'(write_en), 32'(c % 2));
    end
    next_cycle();
    idle_in();
    mon();
    chk("t2_drain", sb.size(), 0);

    // full backpressure mid-burst
    do_reset();
    k = 0;
    for (int i = 0; i < 4; i++) push(2, 8'(8'hC0 + i));
    for (int c = 0; c < 9; c++) begin
      if (c > 0) next_cycle();
      full = (c >= 2 && c <= 4);
      req = (k < 4) ? 4'b0100 : 4'b0000;
      last = (k == 3) ? 4'b0100 : 4'b0000;
      set_beat(2, 8'(8'hC0 + k));
      mon();
      if (ack[2] === 1'b1) k++;
      if (full) begin
        chk("t3_full_we", 32'(write_en), 0);
        chk("t3_full_grant", 32'(grant), 32'b0100);
      end
      if (c == 8) chk("t3_end_grant", 32'(grant), 0);
    end
    chk("t3_total", k, 4);
    idle_in();
    chk("t3_drain", sb.size(), 0);

    // abort by req drop
    do_reset();
    req = 4'b1000;
    set_beat(3, 8'hD0);
    push(3, 8'hD0);
    push(3, 8'hD1);
    push(0, 8'hE0);
    mon();
    next_cycle();
    mon();
    chk("t4_c1_abort", 32'(burst_abort), 0);
    next_cycle();
    set_beat(3, 8'hD1);
    mon();
    next_cycle();
    req = 4'b0001;
    last = 4'b0001;
    set_beat(0, 8'hE0);
    mon();
    chk("t4_c3_we", 32'(write_en), 0);
    next_cycle();
    mon();
    chk("t4_c4_abort", 32'(burst_abort), 1);
    chk("t4_c4_grant", 32'(grant), 0);
    next_cycle();
    mon();
    chk("t4_c5_abort", 32'(burst_abort), 0);
    chk("t4_c5_grant", 32'(grant), 32'b0001);
    next_cycle();
    idle_in();
    mon();
    chk("t4_drain", sb.size(), 0);

    // reset mid-burst
    do_reset();
    req = 4'b0010;
    set_beat(1, 8'hF0);
    push(1, 8'hF0);
    mon();
    next_cycle();
    mon();
    next_cycle();
    reset = 1'b1;
    set_beat(1, 8'hF1);
    mon();
    chk("t5_c2_we", 32'(write_en), 0);
    next_cycle();
    reset = 1'b0;
    req = 4'b0110;
    last = 4'b0110;
    set_beat(1, 8'hF2);
    set_beat(2, 8'hF3);
    push(1, 8'hF2);
    mon();
    chk("t5_c3_grant", 32'(grant), 0);
    chk("t5_c3_busy", 32'(busy), 0);
    chk("t5_c3_we", 32'(write_en), 0);
    next_cycle();
    mon();
    chk("t5_c4_grant", 32'(grant), 32'b0010);
    next_cycle();
    idle_in();
    mon();
    chk("t5_drain", sb.size(), 0);

`ifdef ARB_BURST_LIMIT_EN
    // burst capped at MAX_BURST beats
    do_reset();
    k = 0;
    req = 4'b0011;
    last = 4'b0010;
    set_beat(1, 8'h77);
    for (int i = 0; i < 8; i++) push(0, 8'(8'h30 + i));
    push(1, 8'h77);
    for (int c = 0; c < 11; c++) begin
      if (c > 0) next_cycle();
      set_beat(0, 8'(8'h30 + k));
      mon();
      if (ack[0] === 1'b1) k++;
      chk("t6_abort", 32'(burst_abort), 0);
      if (c == 9) chk("t6_c9_grant", 32'(grant), 0);
      if (c == 10) chk("t6_c10_grant", 32'(grant), 32'b0010);
    end
    chk("t6_beats", k, 8);
    next_cycle();
    idle_in();
    mon();
    chk("t6_drain", sb.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
